// File: rtl/conbus_rr_arb_wdt.sv
// Round-robin grant for the shared conbus, plus a watchdog that force-acks
// any stb the slaves leave unanswered for TIMEOUT cycles.
module conbus_rr_arb_wdt #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 bus_cyc,
  input  logic                 bus_stb,
  input  logic                 bus_ack,
  output logic [N_MASTERS-1:0] gnt,
  output logic [2:0]           gnt_idx,
  output logic                 to_ack,
  output logic                 to_err,
  output logic [7:0]           err_cnt,
  output logic [2:0]           err_master
);

  localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [N_MASTERS-1:0] OneHot0 = N_MASTERS'(1);

  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [2:0]           gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]     wd_q, wd_d;
  logic                 to_ack_q, to_ack_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [2:0]           err_master_q, err_master_d;

  logic [IdxW-1:0] win, cand;
  logic            found, gnt_chg, stall, fire;

  // Rotating search starting at the holder: a holder still requesting keeps
  // the bus (no preemption); otherwise the next requester after it wins.
  // With no requests the grant stays parked on the last holder.
  always_comb begin
    win   = IdxW'(gnt_idx_q);
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < int'(N_MASTERS); k++) begin
      cand = IdxW'((int'(gnt_idx_q) + k) % int'(N_MASTERS));
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    gnt_d     = OneHot0 << win;
    gnt_idx_d = 3'(win);
    gnt_chg   = (gnt_d != gnt_q);
  end

  // A grant change abandons the stall count so the new master never sees a
  // timeout earned by the previous one.
  always_comb begin
    stall        = bus_cyc & bus_stb & ~bus_ack & ~to_ack_q;
    fire         = stall & ~gnt_chg & (wd_q == CNT_W'(TIMEOUT - 1));
    wd_d         = (stall && !gnt_chg && !fire) ? wd_q + 1'b1 : '0;
    to_ack_d     = fire;
    err_cnt_d    = err_cnt_q;
    err_master_d = err_master_q;
    if (fire) begin
      err_master_d = gnt_idx_q;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gnt_q        <= OneHot0;
      gnt_idx_q    <= '0;
      wd_q         <= '0;
      to_ack_q     <= 1'b0;
      err_cnt_q    <= '0;
      err_master_q <= '0;
    end else begin
      gnt_q        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      wd_q         <= wd_d;
      to_ack_q     <= to_ack_d;
      err_cnt_q    <= err_cnt_d;
      err_master_q <= err_master_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_idx    = gnt_idx_q;
  assign to_ack     = to_ack_q;
  assign to_err     = to_ack_q;
  assign err_cnt    = err_cnt_q;
  assign err_master = err_master_q;

endmodule

// File: tb/tb_conbus_rr_arb_wdt.sv
// Scoreboarded bench: driver predicts each cycle's outputs from the arbitration
// and watchdog rules; a separate monitor compares them against the DUT.
module tb_conbus_rr_arb_wdt;
  localparam int N  = 3;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         bus_cyc = 1'b0, bus_stb = 1'b0, bus_ack = 1'b0;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx, err_master;
  logic         to_ack, to_err;
  logic [7:0]   err_cnt;

  always #5 clk = ~clk;

  conbus_rr_arb_wdt #(.N_MASTERS(N), .TIMEOUT(TO), .CNT_W(8)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .req(req), .bus_cyc(bus_cyc), .bus_stb(bus_stb),
    .bus_ack(bus_ack), .gnt(gnt), .gnt_idx(gnt_idx), .to_ack(to_ack), .to_err(to_err),
    .err_cnt(err_cnt), .err_master(err_master)
  );

  typedef struct {
    int idx;
    int ack;
    int ecnt;
    int emast;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Reference state: current holder, length of the current stall run,
  // whether a forced ack is on the bus now, and the error log.
  int m_h = 0, m_run = 0, m_ack = 0, m_cnt = 0, m_em = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [N-1:0] rq, input bit c, input bit s,
                       input bit a);
    exp_t e;
    int   nh;
    bit   stall, fire;
    @(negedge clk);
    sys_rst = r; req = rq; bus_cyc = c; bus_stb = s; bus_ack = a;
    if (r) begin
      m_h = 0; m_run = 0; m_ack = 0; m_cnt = 0; m_em = 0;
    end else begin
      nh = m_h;
      if (!rq[m_h]) begin
        for (int k = 1; k <= N; k++) begin
          if (rq[(m_h + k) % N]) begin
            nh = (m_h + k) % N;
            break;
          end
        end
      end
      stall = c && s && !a && (m_ack == 0);
      // The TIMEOUT-th consecutive stall cycle on an unchanged grant times out.
      fire  = stall && (nh == m_h) && (m_run + 1 == TO);
      if (fire) begin
        m_em  = m_h;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      m_run = (stall && nh == m_h && !fire) ? m_run + 1 : 0;
      m_ack = fire ? 1 : 0;
      m_h   = nh;
    end
    e.idx = m_h; e.ack = m_ack; e.ecnt = m_cnt; e.emast = m_em;
    sb.push_back(e);
  endtask

  // Monitor: one prediction per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt_idx", int'(gnt_idx), e.idx);
        chk("gnt", int'(gnt), 1 << e.idx);
        chk("to_ack", int'(to_ack), e.ack);
        chk("to_err", int'(to_err), e.ack);
        chk("err_cnt", int'(err_cnt), e.ecnt);
        chk("err_master", int'(err_master), e.emast);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] rq;
    // Reset, then idle with no requests.
    repeat (2) drive(1, '0, 0, 0, 0);
    repeat (10) drive(0, '0, 0, 0, 0);
    // Every master requesting; each holder releases for one cycle after four.
    for (int r = 0; r < 5; r++) begin
      repeat (4) drive(0, 3'b111, 0, 0, 0);
      rq = 3'b111;
      rq[m_h] = 1'b0;
      drive(0, rq, 0, 0, 0);
    end
    // Stb held without ack: forced termination after TIMEOUT stall cycles.
    repeat (20) drive(0, 3'b001, 1, 1, 0);
    drive(0, 3'b001, 0, 0, 0);
    // Ack just before the limit, then a fresh stall run.
    repeat (6) drive(0, 3'b001, 1, 1, 0);
    drive(0, 3'b001, 1, 1, 1);
    repeat (12) drive(0, 3'b001, 1, 1, 0);
    // Master 1 stalled mid-count, then reset pulsed.
    repeat (6) drive(0, 3'b010, 1, 1, 0);
    drive(1, 3'b010, 1, 1, 0);
    repeat (12) drive(0, 3'b000, 0, 0, 0);
    // Randomized traffic with occasional acks, grant churn and resets.
    for (int i = 0; i < 1500; i++) begin
      rq = ($urandom_range(0, 7) == 0) ? N'($urandom) : req;
      drive(($urandom_range(0, 299) == 0), rq, ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 11) == 0));
    end
    // Enough forced timeouts to saturate the error counter.
    drive(1, 3'b100, 0, 0, 0);
    repeat (300 * (TO + 1) + 5) drive(0, 3'b100, 1, 1, 0);
    repeat (4) drive(0, 3'b000, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
